// File: rtl/axi4lite_intr_pkg.sv
// Shared definitions for the AXI4-Lite interrupt controller slave:
// register offsets, response code, FSM state types and mask helpers.
package axi4lite_intr_pkg;

  localparam logic [31:0] ADDR_GIER = 32'h0000_0000;
  localparam logic [31:0] ADDR_IER  = 32'h0000_0004;
  localparam logic [31:0] ADDR_ISR  = 32'h0000_0008;
  localparam logic [31:0] ADDR_IACK = 32'h0000_000C;
  localparam logic [31:0] ADDR_IPR  = 32'h0000_0010;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Mask of implemented interrupt bits; unimplemented bits stay zero.
  function automatic logic [31:0] impl_mask(input int num);
    if (num >= 32) return '1;
    return (32'd1 << num) - 32'd1;
  endfunction

endpackage

// File: rtl/axi4lite_intr_detect.sv
// Per-source interrupt detection and status (ISR) bookkeeping.
// Edge mode latches a 0->1 transition against the registered previous
// source value; level mode latches every cycle the source is high.
// A set in the same cycle as an acknowledge wins over the acknowledge.
module axi4lite_intr_detect
  import axi4lite_intr_pkg::*;
#(
  parameter int C_NUM_OF_INTR     = 1,
  parameter int C_IRQ_SENSITIVITY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] src,
  input  logic [31:0] ack,
  output logic [31:0] isr
);

  localparam logic [31:0] MASK = impl_mask(C_NUM_OF_INTR);

  logic [31:0] src_p1;
  logic [31:0] set;

  // Set condition per bit, chosen by sensitivity mode.
  always_comb begin
    set = '0;
    if (C_IRQ_SENSITIVITY != 0) set = src & ~src_p1 & MASK;
    else                        set = src & MASK;
  end

  // Source history and status register; set has priority over ack.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_p1 <= '0;
      isr    <= '0;
    end else begin
      src_p1 <= src & MASK;
      isr    <= ((isr & ~ack) | set) & MASK;
    end
  end

endmodule

// File: rtl/axi4lite_intr_slave.sv
// AXI4-Lite interrupt controller slave.
// Registers: GIER (0x00), IER (0x04), ISR (0x08), IACK (0x0C), IPR (0x10).
// Optional feature macro AXI4LITE_INTR_TEST_GEN_EN: a 4-bit counter, running
// while GIER[0]=1, whose 15->0 wrap pulses are ORed into source bit 0.
module axi4lite_intr_slave
  import axi4lite_intr_pkg::*;
#(
  parameter int C_NUM_OF_INTR      = 1,
  parameter int C_IRQ_SENSITIVITY  = 1,
  parameter int C_IRQ_ACTIVE_STATE = 1,
  parameter int C_ADDR_WIDTH       = 5
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  input  logic [C_NUM_OF_INTR-1:0] intr_src,
  output logic                     irq
);

  localparam logic [31:0] IMPL_MASK = impl_mask(C_NUM_OF_INTR);

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;

  logic                    ready_en;
  logic                    aw_held, w_held;
  logic [C_ADDR_WIDTH-1:0] waddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic                    aw_hs, w_hs, ar_hs, do_write;
  logic [31:0]             wa_off, ra_off, wmask, rd_mux;
  logic [31:0]             src_vec, ack_vec, isr, ier;
  logic                    gier, irq_q, tg_pulse;

  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  assign wa_off = 32'(waddr_q) & ~32'h3;
  assign ra_off = 32'(S_AXI_ARADDR) & ~32'h3;
  assign wmask  = strb_mask(wstrb_q);

  // Keeps all ready outputs low during the cycle reset is applied.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_next        = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    do_write      = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en && !aw_held;
        S_AXI_WREADY  = ready_en && !w_held;
        if (aw_held && w_held) begin
          do_write = 1'b1;
          w_next   = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Tracks which halves of the pending write have been accepted.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (do_write) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
    end
  end

  // Captures write address/data; only meaningful while the held flags are set.
  always_ff @(posedge ACLK) begin
    if (aw_hs) waddr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_next        = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = ready_en;
        if (ar_hs) r_next = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read data mux over the current (pre-update) register values.
  always_comb begin
    rd_mux = '0;
    case (ra_off)
      ADDR_GIER: rd_mux = {31'b0, gier};
      ADDR_IER:  rd_mux = ier;
      ADDR_ISR:  rd_mux = isr;
      ADDR_IPR:  rd_mux = isr & ier;
      default:   rd_mux = '0;
    endcase
  end

  // Read data register, loaded on the address handshake and held until taken.
  always_ff @(posedge ACLK) begin
    if (!ARESETN)   S_AXI_RDATA <= '0;
    else if (ar_hs) S_AXI_RDATA <= rd_mux;
  end

  // GIER and IER updates with per-byte strobe gating.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      gier <= 1'b0;
      ier  <= '0;
    end else if (do_write) begin
      if (wa_off == ADDR_GIER && wstrb_q[0]) gier <= wdata_q[0];
      if (wa_off == ADDR_IER) ier <= ((ier & ~wmask) | (wdata_q & wmask)) & IMPL_MASK;
    end
  end

  // Acknowledge pulse lasts only for the write-update cycle.
  always_comb begin
    ack_vec = '0;
    if (do_write && wa_off == ADDR_IACK) ack_vec = wdata_q & wmask & IMPL_MASK;
  end

`ifdef AXI4LITE_INTR_TEST_GEN_EN
  logic [3:0] tg_cnt;

  // Free-running test counter, advancing only while interrupts are enabled.
  always_ff @(posedge ACLK) begin
    if (!ARESETN)  tg_cnt <= 4'd0;
    else if (gier) tg_cnt <= tg_cnt + 4'd1;
  end

  assign tg_pulse = gier && (tg_cnt == 4'hF);
`else
  assign tg_pulse = 1'b0;
`endif

  assign src_vec = 32'(intr_src) | {31'b0, tg_pulse};

  axi4lite_intr_detect #(
    .C_NUM_OF_INTR     (C_NUM_OF_INTR),
    .C_IRQ_SENSITIVITY (C_IRQ_SENSITIVITY)
  ) u_detect (
    .clk    (ACLK),
    .resetn (ARESETN),
    .src    (src_vec),
    .ack    (ack_vec),
    .isr    (isr)
  );

  // Registered interrupt request: global enable AND any pending enabled source.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) irq_q <= 1'b0;
    else          irq_q <= gier && (|(isr & ier));
  end

  assign irq = (C_IRQ_ACTIVE_STATE != 0) ? irq_q : ~irq_q;

endmodule

// File: tb/tb_axi4lite_intr_slave.sv
// Directed testbench for axi4lite_intr_slave (4 sources, edge mode, active-high irq).
module tb_axi4lite_intr_slave;

  logic        clk;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [3:0]  intr_src;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;
  logic [1:0]  rr;

  axi4lite_intr_slave #(
    .C_NUM_OF_INTR      (4),
    .C_IRQ_SENSITIVITY  (1),
    .C_IRQ_ACTIVE_STATE (1),
    .C_ADDR_WIDTH       (5)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .intr_src      (intr_src),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    logic aw_go, w_go;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL write_accept_timeout addr=%h awvalid=%0b wvalid=%0b", a, awvalid, wvalid);
      awvalid = 1'b0; wvalid = 1'b0;
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL bvalid_timeout addr=%h got=0 exp=1", a);
    end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL arready_timeout addr=%h got=0 exp=1", a);
    end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL rvalid_timeout addr=%h got=0 exp=1", a);
    end
    d = rdata; r = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] v);
    @(negedge clk); intr_src = v;
    @(negedge clk); intr_src = 4'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (awready !== 1'b0) begin bad++; $display("FAIL rst_awready got=%0b exp=0", awready); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL rst_wready got=%0b exp=0", wready); end
    total++; if (arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%0b exp=0", arready); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%0b exp=0", bvalid); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b exp=0", rvalid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%0b exp=0", irq); end
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(5'h00, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_gier got=%h exp=0", rd); end
    axi_read(5'h04, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_ier got=%h exp=0", rd); end
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_isr got=%h exp=0", rd); end
    axi_read(5'h10, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_ipr got=%h exp=0", rd); end
  endtask

  task automatic test_irq_edge;
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h1, 4'hF);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_before_pulse got=%0b exp=0", irq); end
    @(negedge clk); intr_src = 4'h1;
    @(negedge clk); intr_src = 4'h0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_one_cycle got=%0b exp=0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_two_cycles got=%0b exp=1", irq); end
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL edge_isr got=%h exp=1", rd); end
    axi_read(5'h10, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL edge_ipr got=%h exp=1", rd); end
  endtask

  task automatic test_iack;
    axi_write(5'h0C, 32'h1, 4'hF);
    axi_read(5'h10, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL iack_ipr got=%h exp=0", rd); end
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL iack_isr got=%h exp=0", rd); end
    axi_read(5'h0C, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL iack_reads0 got=%h exp=0", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL iack_irq got=%0b exp=0", irq); end
  endtask

  task automatic test_gier_clear;
    axi_write(5'h04, 32'h3, 4'hF);
    pulse_src(4'h2);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL gier_irq_set got=%0b exp=1", irq); end
    axi_write(5'h00, 32'h0, 4'hF);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL gier_clear_irq got=%0b exp=0", irq); end
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL gier_clear_isr got=%h exp=2", rd); end
    axi_write(5'h00, 32'h1, 4'hF);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL gier_reenable_irq got=%0b exp=1", irq); end
    axi_write(5'h0C, 32'h2, 4'hF);
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL gier_ack_isr got=%h exp=0", rd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL gier_ack_irq got=%0b exp=0", irq); end
  endtask

  task automatic test_b_hold;
    int n;
    @(negedge clk);
    awaddr = 5'h04; awvalid = 1'b1;
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL bh_awready got=%0b exp=1", awready); end
    @(negedge clk); awvalid = 1'b0;
    repeat (2) @(negedge clk);
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL bh_wready got=%0b exp=1", wready); end
    @(negedge clk); wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL bh_bvalid_timeout got=%0b exp=1", bvalid); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL bh_bvalid_held cyc=%0d got=%0b exp=1", i, bvalid); end
      total++; if (bresp !== 2'b00) begin bad++; $display("FAIL bh_bresp cyc=%0d got=%0d exp=0", i, bresp); end
      total++; if (awready !== 1'b0) begin bad++; $display("FAIL bh_awready_low cyc=%0d got=%0b exp=0", i, awready); end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL bh_single_b cyc=%0d got=%0b exp=0", i, bvalid); end
      @(negedge clk);
    end
    axi_read(5'h04, rd, rr);
    total++; if (rd !== 32'h5) begin bad++; $display("FAIL bh_ier got=%h exp=5", rd); end
  endtask

  task automatic test_strobe;
    axi_write(5'h04, 32'h1, 4'hF);
    axi_write(5'h04, 32'hFFFF_FFFF, 4'h0);
    axi_read(5'h04, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL strb0_ier got=%h exp=1", rd); end
    axi_write(5'h04, 32'hFFFF_FFFF, 4'h1);
    axi_read(5'h04, rd, rr);
    total++; if (rd !== 32'hF) begin bad++; $display("FAIL strb_impl_bits got=%h exp=f", rd); end
    axi_read(5'h14, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_rd got=%h exp=0", rd); end
    total++; if (rr !== 2'b00) begin bad++; $display("FAIL unmapped_rresp got=%0d exp=0", rr); end
    axi_write(5'h00, 32'h0, 4'h2);
    axi_write(5'h18, 32'h0, 4'hF);
    axi_read(5'h00, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL gier_strb_gate got=%h exp=1", rd); end
    axi_read(5'h07, rd, rr);
    total++; if (rd !== 32'hF) begin bad++; $display("FAIL addr_lsb_ignored got=%h exp=f", rd); end
    axi_write(5'h04, 32'h1, 4'hF);
  endtask

  task automatic test_simul;
    @(negedge clk);
    awaddr = 5'h04; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h04; arvalid = 1'b1;
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL sim_arready got=%0b exp=1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL sim_rvalid got=%0b exp=1", rvalid); end
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL sim_pre_update got=%h exp=1", rdata); end
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL sim_bvalid got=%0b exp=1", bvalid); end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL sim_rvalid_drop got=%0b exp=0", rvalid); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL sim_bvalid_drop got=%0b exp=0", bvalid); end
    axi_read(5'h04, rd, rr);
    total++; if (rd !== 32'h3) begin bad++; $display("FAIL sim_post_update got=%h exp=3", rd); end
  endtask

  task automatic test_ack_vs_set;
    pulse_src(4'h1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; intr_src = 4'h1;
    @(negedge clk);
    intr_src = 4'h0;
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL race_bvalid got=%0b exp=1", bvalid); end
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL race_set_wins got=%h exp=1", rd); end
    axi_write(5'h0C, 32'h1, 4'hF);
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL race_cleanup got=%h exp=0", rd); end
  endtask

`ifdef AXI4LITE_INTR_TEST_GEN_EN
  task automatic test_test_gen;
    int n;
    intr_src = 4'h0;
    axi_write(5'h04, 32'h1, 4'hF);
    axi_write(5'h00, 32'h1, 4'hF);
    n = 0;
    while (irq !== 1'b1 && n < 18) begin @(negedge clk); n++; end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL testgen_irq got=%0b exp=1", irq); end
  endtask
`endif

  task automatic test_reset_mid_write;
    int n;
    pulse_src(4'h1);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_irq_pre got=%0b exp=1", irq); end
    @(negedge clk);
    awaddr = 5'h04; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL mid_bvalid_pre got=%0b exp=1", bvalid); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL mid_bvalid_rst got=%0b exp=0", bvalid); end
    total++; if (awready !== 1'b0) begin bad++; $display("FAIL mid_awready_rst got=%0b exp=0", awready); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq_rst got=%0b exp=0", irq); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL mid_bvalid_after got=%0b exp=0", bvalid); end
    axi_read(5'h00, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_gier got=%h exp=0", rd); end
    axi_read(5'h04, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_ier got=%h exp=0", rd); end
    axi_read(5'h08, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_isr got=%h exp=0", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; intr_src = '0;
    test_reset;
    test_irq_edge;
    test_iack;
    test_gier_clear;
    test_b_hold;
    test_strobe;
    test_simul;
    test_ack_vs_set;
`ifdef AXI4LITE_INTR_TEST_GEN_EN
    test_test_gen;
`endif
    test_reset_mid_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
